// File: rtl/perceptron_trainer.sv
// Training sequencer for a single perceptron: stores labelled samples and replays them
// for a programmed number of epochs, returning target-minus-result errors.
// Optional feature macro: PERCEPTRON_TRAINER_EARLY_STOP_EN (finish once an epoch has no misses).
module perceptron_trainer #(
    parameter int unsigned ARGD  = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   smp_stb,
    input  logic [8*ARGD+7:0]      smp_dat,
    output logic                   smp_rdy,
    input  logic                   clr,
    input  logic                   start,
    input  logic [7:0]             epochs,
    output logic                   busy,
    output logic                   done,
    output logic [7:0]             epoch_cnt,
    output logic [7:0]             miss_cnt,
    output logic                   arg_stb,
    output logic [8*ARGD-1:0]      arg_dat,
    input  logic                   arg_rdy,
    input  logic                   res_stb,
    input  logic [7:0]             res_dat,
    output logic                   res_rdy,
    output logic                   err_stb,
    output logic [15:0]            err_dat,
    input  logic                   err_rdy,
    input  logic                   fbk_stb,
    input  logic [16*ARGD-1:0]     fbk_dat,
    output logic                   fbk_rdy
);

    localparam int unsigned AW = 8 * ARGD;
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = IW + 1;

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StArg  = 3'd1;
    localparam logic [2:0] StRes  = 3'd2;
    localparam logic [2:0] StErr  = 3'd3;
    localparam logic [2:0] StFbk  = 3'd4;
    localparam logic [2:0] StNext = 3'd5;
    localparam logic [2:0] StDone = 3'd6;

    logic [2:0]     state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [7:0]     epochs_q, epochs_d;
    logic [7:0]     epoch_cnt_q, epoch_cnt_d;
    logic [7:0]     miss_acc_q, miss_acc_d;
    logic [7:0]     miss_cnt_q, miss_cnt_d;
    logic [15:0]    err_q, err_d;
    logic [AW+7:0]  store_q [DEPTH];

    logic           smp_we;
    logic [AW+7:0]  cur;
    logic [7:0]     cur_tgt;
    logic [8:0]     diff;
    logic           last_smp;
    logic           stop_now;
    logic           unused_fbk;

    // Feedback weights are only drained, never inspected.
    assign unused_fbk = ^fbk_dat;

    assign smp_rdy  = (state_q == StIdle) && (count_q < CW'(DEPTH));
    assign smp_we   = smp_stb && smp_rdy && !clr;
    assign cur      = store_q[idx_q];
    assign cur_tgt  = cur[AW+7:AW];
    assign diff     = {1'b0, cur_tgt} - {1'b0, res_dat};
    assign last_smp = ({1'b0, idx_q} == (count_q - CW'(1)));

`ifdef PERCEPTRON_TRAINER_EARLY_STOP_EN
    assign stop_now = ((epoch_cnt_q + 8'd1) == epochs_q) || (miss_acc_q == 8'd0);
`else
    assign stop_now = ((epoch_cnt_q + 8'd1) == epochs_q);
`endif

    assign arg_stb   = (state_q == StArg);
    assign arg_dat   = cur[AW-1:0];
    assign res_rdy   = (state_q == StRes);
    assign err_stb   = (state_q == StErr);
    assign err_dat   = err_q;
    assign fbk_rdy   = (state_q == StFbk);
    assign done      = (state_q == StDone);
    assign busy      = (state_q == StArg) || (state_q == StRes) || (state_q == StErr) ||
                       (state_q == StFbk) || (state_q == StNext);
    assign epoch_cnt = epoch_cnt_q;
    assign miss_cnt  = miss_cnt_q;

    // Next-state logic for the sequencer, store occupancy and statistics.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        idx_d       = idx_q;
        epochs_d    = epochs_q;
        epoch_cnt_d = epoch_cnt_q;
        miss_acc_d  = miss_acc_q;
        miss_cnt_d  = miss_cnt_q;
        err_d       = err_q;
        case (state_q)
            StIdle: begin
                if (clr) begin
                    count_d = '0;
                end else if (smp_we) begin
                    count_d = count_q + CW'(1);
                end
                if (start) begin
                    // clr in the same cycle empties the store first, so training is skipped.
                    if (clr || (count_q == '0) || (epochs == 8'd0)) begin
                        state_d = StDone;
                    end else begin
                        epochs_d    = epochs;
                        idx_d       = '0;
                        epoch_cnt_d = 8'd0;
                        miss_acc_d  = 8'd0;
                        miss_cnt_d  = 8'd0;
                        state_d     = StArg;
                    end
                end
            end
            StArg: begin
                if (arg_rdy) state_d = StRes;
            end
            StRes: begin
                if (res_stb) begin
                    err_d = {{7{diff[8]}}, diff};
                    if ((res_dat != cur_tgt) && (miss_acc_q != 8'hFF)) begin
                        miss_acc_d = miss_acc_q + 8'd1;
                    end
                    state_d = StErr;
                end
            end
            StErr: begin
                if (err_rdy) state_d = StFbk;
            end
            StFbk: begin
                if (fbk_stb) state_d = StNext;
            end
            StNext: begin
                if (!last_smp) begin
                    idx_d   = idx_q + IW'(1);
                    state_d = StArg;
                end else begin
                    epoch_cnt_d = epoch_cnt_q + 8'd1;
                    miss_cnt_d  = miss_acc_q;
                    miss_acc_d  = 8'd0;
                    idx_d       = '0;
                    state_d     = stop_now ? StDone : StArg;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control and statistics registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            count_q     <= '0;
            idx_q       <= '0;
            epochs_q    <= 8'd0;
            epoch_cnt_q <= 8'd0;
            miss_acc_q  <= 8'd0;
            miss_cnt_q  <= 8'd0;
            err_q       <= 16'd0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            epochs_q    <= epochs_d;
            epoch_cnt_q <= epoch_cnt_d;
            miss_acc_q  <= miss_acc_d;
            miss_cnt_q  <= miss_cnt_d;
            err_q       <= err_d;
        end
    end

    // Sample store; contents are only meaningful below count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (smp_we) begin
            store_q[count_q[IW-1:0]] <= smp_dat;
        end
    end

endmodule

// File: tb/tb_perceptron_trainer.sv
// Self-checking bench for perceptron_trainer: randomized perceptron responses and
// back-pressure, checked against a sample/epoch-level reference model.
module tb_perceptron_trainer;

    localparam int ARGD  = 2;
    localparam int DEPTH = 4;

`ifdef PERCEPTRON_TRAINER_EARLY_STOP_EN
    localparam bit EarlyStop = 1'b1;
`else
    localparam bit EarlyStop = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 smp_stb = 1'b0;
    logic [8*ARGD+7:0]    smp_dat = '0;
    logic                 smp_rdy;
    logic                 clr = 1'b0;
    logic                 start = 1'b0;
    logic [7:0]           epochs = 8'd0;
    logic                 busy;
    logic                 done;
    logic [7:0]           epoch_cnt;
    logic [7:0]           miss_cnt;
    logic                 arg_stb;
    logic [8*ARGD-1:0]    arg_dat;
    logic                 arg_rdy = 1'b0;
    logic                 res_stb = 1'b0;
    logic [7:0]           res_dat = 8'd0;
    logic                 res_rdy;
    logic                 err_stb;
    logic [15:0]          err_dat;
    logic                 err_rdy = 1'b0;
    logic                 fbk_stb = 1'b0;
    logic [16*ARGD-1:0]   fbk_dat = '0;
    logic                 fbk_rdy;

    perceptron_trainer #(.ARGD(ARGD), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .smp_stb(smp_stb), .smp_dat(smp_dat), .smp_rdy(smp_rdy),
        .clr(clr), .start(start), .epochs(epochs),
        .busy(busy), .done(done), .epoch_cnt(epoch_cnt), .miss_cnt(miss_cnt),
        .arg_stb(arg_stb), .arg_dat(arg_dat), .arg_rdy(arg_rdy),
        .res_stb(res_stb), .res_dat(res_dat), .res_rdy(res_rdy),
        .err_stb(err_stb), .err_dat(err_dat), .err_rdy(err_rdy),
        .fbk_stb(fbk_stb), .fbk_dat(fbk_dat), .fbk_rdy(fbk_rdy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int arg_n = 0, res_n = 0, err_n = 0, fbk_n = 0, done_n = 0;

    // Reference store contents
    logic [15:0] m_args [DEPTH];
    logic [7:0]  m_tgt  [DEPTH];
    logic [7:0]  res_tab[DEPTH];
    int          m_cnt = 0;

    // Transfer counters observed on every stream
    always @(posedge clk) begin
        if (arg_stb && arg_rdy) arg_n <= arg_n + 1;
        if (res_stb && res_rdy) res_n <= res_n + 1;
        if (err_stb && err_rdy) err_n <= err_n + 1;
        if (fbk_stb && fbk_rdy) fbk_n <= fbk_n + 1;
        if (done)               done_n <= done_n + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic write_sample(input logic [7:0] t, input logic [15:0] a);
        check_eq("smp_rdy", {31'd0, smp_rdy}, {31'd0, m_cnt < DEPTH});
        smp_stb = 1'b1;
        smp_dat = {t, a};
        @(negedge clk);
        smp_stb = 1'b0;
        if (m_cnt < DEPTH) begin
            m_args[m_cnt] = a;
            m_tgt[m_cnt]  = t;
            m_cnt++;
        end
    endtask

    task automatic clear_store();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        m_cnt = 0;
    endtask

    // Plays the perceptron for one sample; returns the argument and error it saw.
    task automatic serve_sample(input logic [7:0] rv, output logic [15:0] got_arg,
                                output logic [15:0] got_err);
        int n;
        int d;
        logic [15:0] first;
        logic hold_ok;
        got_arg = 16'hxxxx;
        got_err = 16'hxxxx;
        // A result offered early must not be taken before the argument goes out.
        if ($urandom_range(0, 1) == 1) begin
            res_stb = 1'b1;
            res_dat = rv;
        end
        n = 0;
        while (!arg_stb && n < 50) begin @(negedge clk); n++; end
        check_eq("arg_seen", {31'd0, arg_stb}, 32'd1);
        if (!arg_stb) return;
        first = arg_dat;
        hold_ok = 1'b1;
        d = $urandom_range(0, 5);
        repeat (d) begin
            @(negedge clk);
            if (!arg_stb || arg_dat !== first) hold_ok = 1'b0;
        end
        check_eq("arg_hold", {31'd0, hold_ok}, 32'd1);
        got_arg = arg_dat;
        arg_rdy = 1'b1;
        @(negedge clk);
        arg_rdy = 1'b0;
        res_stb = 1'b1;
        res_dat = rv;
        n = 0;
        while (!res_rdy && n < 50) begin @(negedge clk); n++; end
        check_eq("res_rdy_seen", {31'd0, res_rdy}, 32'd1);
        @(negedge clk);
        res_stb = 1'b0;
        res_dat = 8'($urandom);
        n = 0;
        while (!err_stb && n < 50) begin @(negedge clk); n++; end
        check_eq("err_seen", {31'd0, err_stb}, 32'd1);
        first = err_dat;
        hold_ok = 1'b1;
        d = $urandom_range(0, 5);
        repeat (d) begin
            @(negedge clk);
            if (!err_stb || err_dat !== first) hold_ok = 1'b0;
        end
        check_eq("err_hold", {31'd0, hold_ok}, 32'd1);
        got_err = err_dat;
        err_rdy = 1'b1;
        @(negedge clk);
        err_rdy = 1'b0;
        n = 0;
        while (!fbk_rdy && n < 50) begin @(negedge clk); n++; end
        check_eq("fbk_rdy_seen", {31'd0, fbk_rdy}, 32'd1);
        d = $urandom_range(0, 5);
        repeat (d) @(negedge clk);
        fbk_stb = 1'b1;
        fbk_dat = $urandom;
        @(negedge clk);
        fbk_stb = 1'b0;
    endtask

    // mode: 0 result always 0, 1 perfect, 2 random, 3 from res_tab
    task automatic run_training(input int eps, input int mode, input bit with_clr);
        int a0, r0, e0, f0, d0;
        int ep_run;
        int misses;
        int n;
        bit stop;
        logic [7:0]  rv;
        logic [15:0] ga, ge, ee;
        a0 = arg_n; r0 = res_n; e0 = err_n; f0 = fbk_n; d0 = done_n;
        epochs = 8'(eps);
        start  = 1'b1;
        if (with_clr) begin
            clr = 1'b1;
            m_cnt = 0;
        end
        @(negedge clk);
        start = 1'b0;
        clr   = 1'b0;
        if (m_cnt == 0 || eps == 0) begin
            check_eq("quick_done", {31'd0, done}, 32'd1);
            check_eq("quick_busy", {31'd0, busy}, 32'd0);
            @(negedge clk);
            check_eq("quick_done_end", {31'd0, done}, 32'd0);
            check_eq("quick_no_arg", arg_n - a0, 32'd0);
            check_eq("quick_done_cnt", done_n - d0, 32'd1);
            return;
        end
        ep_run = 0;
        misses = 0;
        stop = 1'b0;
        for (int ep = 0; ep < eps && !stop; ep++) begin
            misses = 0;
            for (int i = 0; i < m_cnt; i++) begin
                case (mode)
                    0: rv = 8'd0;
                    1: rv = m_tgt[i];
                    2: rv = ($urandom_range(0, 1) == 1) ? m_tgt[i] : 8'($urandom);
                    default: rv = res_tab[i];
                endcase
                serve_sample(rv, ga, ge);
                ee = 16'(int'(m_tgt[i]) - int'(rv));
                check_eq("arg_dat", {16'd0, ga}, {16'd0, m_args[i]});
                check_eq("err_dat", {16'd0, ge}, {16'd0, ee});
                if (rv != m_tgt[i]) misses++;
            end
            ep_run++;
            if (EarlyStop && misses == 0) stop = 1'b1;
        end
        n = 0;
        while (!done && n < 10) begin @(negedge clk); n++; end
        check_eq("done_seen", {31'd0, done}, 32'd1);
        @(negedge clk);
        check_eq("done_pulse", {31'd0, done}, 32'd0);
        check_eq("busy_end", {31'd0, busy}, 32'd0);
        check_eq("epoch_cnt", {24'd0, epoch_cnt}, 32'(ep_run));
        check_eq("miss_cnt", {24'd0, miss_cnt}, 32'(misses));
        check_eq("arg_xfers", arg_n - a0, 32'(ep_run * m_cnt));
        check_eq("res_xfers", res_n - r0, 32'(ep_run * m_cnt));
        check_eq("err_xfers", err_n - e0, 32'(ep_run * m_cnt));
        check_eq("fbk_xfers", fbk_n - f0, 32'(ep_run * m_cnt));
        check_eq("done_cnt", done_n - d0, 32'd1);
    endtask

    task automatic load_and();
        clear_store();
        write_sample(8'd0, {8'd0, 8'd0});
        write_sample(8'd0, {8'd1, 8'd0});
        write_sample(8'd0, {8'd0, 8'd1});
        write_sample(8'd1, {8'd1, 8'd1});
    endtask

    initial begin
        int n;
        int a0;
        #3 rst = 1'b0;
        #2;
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_strobes", {28'd0, arg_stb, res_rdy, err_stb, fbk_rdy}, 32'd0);
        check_eq("rst_epoch_cnt", {24'd0, epoch_cnt}, 32'd0);
        check_eq("rst_miss_cnt", {24'd0, miss_cnt}, 32'd0);
        check_eq("rst_err_dat", {16'd0, err_dat}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_smp_rdy", {31'd0, smp_rdy}, 32'd1);

        // Empty store and zero-epoch starts finish without traffic
        run_training(3, 0, 1'b0);
        load_and();
        run_training(0, 0, 1'b0);
        run_training(2, 0, 1'b1);

        // clr beats a simultaneous sample write
        clr = 1'b1;
        smp_stb = 1'b1;
        smp_dat = 24'h01_0203;
        @(negedge clk);
        clr = 1'b0;
        smp_stb = 1'b0;
        m_cnt = 0;
        run_training(2, 0, 1'b0);

        // AND set, result always 0
        load_and();
        run_training(1, 0, 1'b0);

        // Sign of the error: 0-1 and 255-0
        clear_store();
        write_sample(8'h00, 16'h1234);
        write_sample(8'hFF, 16'hABCD);
        res_tab[0] = 8'h01;
        res_tab[1] = 8'h00;
        run_training(1, 3, 1'b0);

        // Store overflow: DEPTH+1 writes, only DEPTH kept
        clear_store();
        for (int i = 0; i <= DEPTH; i++) write_sample(8'($urandom), 16'($urandom));
        check_eq("store_full", {31'd0, smp_rdy}, 32'd0);
        run_training(1, 2, 1'b0);

        // Randomized rounds
        for (int r = 0; r < 6; r++) begin
            clear_store();
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) write_sample(8'($urandom), 16'($urandom));
            run_training($urandom_range(1, 3), 2, 1'b0);
        end

        // Perfect model over many epochs
        load_and();
        run_training(10, 1, 1'b0);

        // Reset while waiting for a result
        load_and();
        epochs = 8'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!arg_stb && n < 20) begin @(negedge clk); n++; end
        arg_rdy = 1'b1;
        @(negedge clk);
        arg_rdy = 1'b0;
        check_eq("mid_in_res", {31'd0, res_rdy}, 32'd1);
        rst = 1'b0;
        #1;
        check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
        check_eq("mid_rst_strobes", {28'd0, arg_stb, res_rdy, err_stb, fbk_rdy}, 32'd0);
        check_eq("mid_rst_done", {31'd0, done}, 32'd0);
        check_eq("mid_rst_err_dat", {16'd0, err_dat}, 32'd0);
        check_eq("mid_rst_epoch_cnt", {24'd0, epoch_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        m_cnt = 0;
        a0 = arg_n;
        repeat (5) @(negedge clk);
        check_eq("mid_no_arg", arg_n - a0, 32'd0);
        check_eq("mid_smp_rdy", {31'd0, smp_rdy}, 32'd1);
        run_training(5, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
